// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the serial-ALU request scheduler.
package alu_sched_pkg;

  localparam int unsigned NREQ_DEF        = 4;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned OP_W_DEF        = 3;
  localparam int unsigned RES_W_DEF       = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_RESP
  } state_e;

  // Opcodes understood by the serial ALU; also used by its test environment.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_SUB = 3'b100,
    OP_MUL = 3'b101
  } op_e;

  // Serial command frame: operand A, operand B, opcode.
  function automatic int unsigned frame_w(input int unsigned data_w, input int unsigned op_w);
    return 2 * data_w + op_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating priority starting just after the last winner.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         grant_oh_c,
  output logic [$clog2(NREQ)-1:0] grant_idx_c,
  output logic                    any_c
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;

  // First requester found searching from ptr+1 with wrap-around.
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NREQ);
      if (!any_c && req_i[cand]) begin
        any_c             = 1'b1;
        grant_idx_c       = cand;
        grant_oh_c[cand]  = 1'b1;
      end
    end
  end

  // Pointer follows the winner; reset value gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NREQ - 1);
    end else if (en_i && any_c) begin
      ptr_q <= grant_idx_c;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one serial ALU among NREQ requesters: grant, serialize, await, deserialize, respond.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ        = NREQ_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned OP_W        = OP_W_DEF,
  parameter int unsigned RES_W       = RES_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DATA_W-1:0]  req_a,
  input  logic [NREQ*DATA_W-1:0]  req_b,
  input  logic [NREQ*OP_W-1:0]    req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    enable_n,
  output logic                    din,
  input  logic                    dout,
  input  logic                    dout_valid
);

  localparam int unsigned IDX_W     = $clog2(NREQ);
  localparam int unsigned FRAME_W   = frame_w(DATA_W, OP_W);
  localparam int unsigned BIT_CNT_W = $clog2(FRAME_W);
  localparam int unsigned RES_CNT_W = $clog2(RES_W);
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q;
  logic [NREQ-1:0]        req_ready_q;
  logic [FRAME_W-1:0]     frame_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [RES_CNT_W-1:0]   res_cnt_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic                   enable_n_q;
  logic                   din_q;
  logic                   rsp_valid_q;
  logic [IDX_W-1:0]       rsp_id_q;
  logic [RES_W-1:0]       rsp_data_q;
  logic                   rsp_err_q;

  logic [NREQ-1:0]        arb_oh_c;
  logic [IDX_W-1:0]       arb_idx_c;
  logic                   arb_any_c;
  logic [FRAME_W-1:0]     cmd_frame_c;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .en_i        (state_q == ST_IDLE),
    .grant_oh_c  (arb_oh_c),
    .grant_idx_c (arb_idx_c),
    .any_c       (arb_any_c)
  );

  // Payload of the winning requester, packed as A, B, opcode (MSB first on the wire).
  assign cmd_frame_c = {req_a[32'(arb_idx_c) * DATA_W +: DATA_W],
                        req_b[32'(arb_idx_c) * DATA_W +: DATA_W],
                        req_op[32'(arb_idx_c) * OP_W +: OP_W]};

  // Scheduler FSM with registered outputs; reset aborts any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= '0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      res_cnt_q   <= '0;
      to_cnt_q    <= '0;
      enable_n_q  <= 1'b1;
      din_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          // Winner is decided here so its accept pulse is visible during GRANT.
          if (arb_any_c) begin
            req_ready_q <= arb_oh_c;
            frame_q     <= cmd_frame_c;
            rsp_id_q    <= arb_idx_c;
            state_q     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          enable_n_q <= 1'b0;
          din_q      <= frame_q[FRAME_W-1];
          frame_q    <= {frame_q[FRAME_W-2:0], 1'b0};
          bit_cnt_q  <= '0;
          rsp_data_q <= '0;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) begin
            enable_n_q <= 1'b1;
            din_q      <= 1'b0;
            to_cnt_q   <= '0;
            state_q    <= ST_WAIT;
          end else begin
            din_q     <= frame_q[FRAME_W-1];
            frame_q   <= {frame_q[FRAME_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // Data arriving on the expiry cycle wins over the timeout.
          if (dout_valid) begin
            rsp_data_q[RES_W-1] <= dout;
            res_cnt_q           <= RES_CNT_W'(1);
            state_q             <= ST_RECV;
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_RECV: begin
          if (dout_valid) begin
            rsp_data_q[RES_CNT_W'(RES_W - 1) - res_cnt_q] <= dout;
            if (res_cnt_q == RES_CNT_W'(RES_W - 1)) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              state_q     <= ST_RESP;
            end else begin
              res_cnt_q <= res_cnt_q + RES_CNT_W'(1);
            end
          end else begin
            // Truncated result: keep the left-aligned partial value and flag it.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign enable_n  = enable_n_q;
  assign din       = din_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: serial ALU model, directed vector table, corner sequences, random batches.
module tb_alu_req_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int OW   = 3;
  localparam int RW   = 16;
  localparam int FW   = 2 * DW + OW;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ*OW-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [RW-1:0]     rsp_data;
  logic              rsp_err;
  logic              enable_n;
  logic              din;
  logic              dout;
  logic              dout_valid;

  alu_req_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    int          bits;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int alu_lat  = 1;
  int alu_bits = 16;
  logic [FW-1:0] last_frame = '0;
  int last_n = 0;

  int last_grant_idx = -1;
  int last_grant_cyc = 0;
  int grant_cnt = 0;
  int onehot_bad = 0;
  int posted = 0;
  int grant_log[$];
  rsp_t rsp_log[$];
  bit auto_ack = 1'b1;

  logic [7:0] pa [NREQ];
  logic [7:0] pb [NREQ];
  logic [2:0] pop [NREQ];

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return 16'(a) + 16'(b);
      3'b001:  return 16'(a & b);
      3'b010:  return 16'(a | b);
      3'b011:  return 16'(a ^ b);
      3'b100:  return 16'(a) - 16'(b);
      3'b101:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial ALU model: collects a frame while enable_n is low, then shifts the result out MSB-first.
  initial begin : alu_model
    logic [FW-1:0] fr;
    logic [15:0]   res;
    int            n;
    dout = 1'b0;
    dout_valid = 1'b0;
    fr = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0;
      end else if (!enable_n) begin
        fr = {fr[FW-2:0], din};
        n++;
      end else if (n > 0) begin
        last_frame = fr;
        last_n = n;
        n = 0;
        res = alu_ref(fr[18:11], fr[10:3], fr[2:0]);
        repeat (alu_lat - 1) @(negedge clk);
        for (int j = 0; j < alu_bits; j++) begin
          dout_valid = 1'b1;
          dout = (j < 16) ? res[15 - j] : 1'b0;
          @(negedge clk);
        end
        dout_valid = 1'b0;
        dout = 1'b0;
      end
    end
  end

  // One clock of the requester/consumer side, sampled at the falling edge.
  task automatic tick();
    rsp_t r;
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      if ($countones(req_ready) != 1) onehot_bad++;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_grant_idx = i;
      last_grant_cyc = cyc;
      grant_cnt++;
      grant_log.push_back(last_grant_idx);
      req_valid = req_valid & ~req_ready;
    end
    if (auto_ack && rsp_valid && !rsp_ready) begin
      r.id = 32'(rsp_id);
      r.data = rsp_data;
      r.err = rsp_err;
      r.cyc = cyc;
      rsp_log.push_back(r);
      rsp_ready = 1'b1;
    end else if (rsp_ready) begin
      rsp_ready = 1'b0;
    end
  endtask

  task automatic post(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*OW +: OW] = op;
    pa[i] = a;
    pb[i] = b;
    pop[i] = op;
    req_valid[i] = 1'b1;
    posted++;
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rsp_arrival", 32'(rsp_log.size()), 32'(n));
  endtask

  vec_t vecs[13];

  initial begin : main
    int n0, g0, pc, ac, viol, exp_lat, ref_ptr, cnt, k;
    int exp_ids[$];
    logic [NREQ-1:0] mask;

    vecs[0]  = '{0, 8'h12, 8'h34, 3'b000, 16, 16'h0046, 1'b0};
    vecs[1]  = '{1, 8'hFF, 8'h01, 3'b000, 16, 16'h0100, 1'b0};
    vecs[2]  = '{2, 8'hF0, 8'h3C, 3'b001, 16, 16'h0030, 1'b0};
    vecs[3]  = '{3, 8'hF0, 8'h0F, 3'b010, 16, 16'h00FF, 1'b0};
    vecs[4]  = '{1, 8'hAA, 8'h55, 3'b011, 16, 16'h00FF, 1'b0};
    vecs[5]  = '{2, 8'h05, 8'h07, 3'b100, 16, 16'hFFFE, 1'b0};
    vecs[6]  = '{3, 8'h0C, 8'h0B, 3'b101, 16, 16'h0084, 1'b0};
    vecs[7]  = '{0, 8'h12, 8'h34, 3'b000, 10, 16'h0040, 1'b1};
    vecs[8]  = '{2, 8'hFF, 8'hFF, 3'b101, 10, 16'hFE00, 1'b1};
    vecs[9]  = '{2, 8'h12, 8'h34, 3'b000, 0,  16'h0000, 1'b1};
    vecs[10] = '{1, 8'h12, 8'h34, 3'b000, 16, 16'h0046, 1'b0};
    vecs[11] = '{0, 8'h9A, 8'hBC, 3'b011, 18, 16'h0026, 1'b0};
    vecs[12] = '{3, 8'hFF, 8'hFF, 3'b101, 16, 16'hFE01, 1'b0};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_enable_n", 32'(enable_n), 32'd1);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // All four contend at once: order 0,1,2,3 from the reset pointer
    alu_lat = 2;
    alu_bits = 16;
    n0 = rsp_log.size();
    g0 = grant_log.size();
    for (int i = 0; i < NREQ; i++) post(i, 8'(8'h10 + i), 8'(8'h20 * i), 3'(i));
    wait_rsps(n0 + 4, 400);
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > g0 + i) chk("rr4_grant", 32'(grant_log[g0 + i]), 32'(i));
      if (rsp_log.size() > n0 + i) begin
        chk("rr4_rsp_id", 32'(rsp_log[n0 + i].id), 32'(i));
        chk("rr4_rsp_data", 32'(rsp_log[n0 + i].data), 32'(alu_ref(pa[i], pb[i], pop[i])));
      end
    end
    // Re-request: 0 and 2 together after 3 was last served
    n0 = rsp_log.size();
    g0 = grant_log.size();
    post(2, 8'h01, 8'h02, 3'b000);
    post(0, 8'h03, 8'h04, 3'b000);
    wait_rsps(n0 + 2, 200);
    if (grant_log.size() >= g0 + 2) begin
      chk("rerq_first", 32'(grant_log[g0]), 32'd0);
      chk("rerq_second", 32'(grant_log[g0 + 1]), 32'd2);
    end

    // Directed single-command table
    alu_lat = 1;
    foreach (vecs[v]) begin
      alu_bits = vecs[v].bits;
      tick();
      tick();
      n0 = rsp_log.size();
      g0 = grant_cnt;
      post(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op);
      pc = cyc;
      wait_rsps(n0 + 1, 300);
      if (rsp_log.size() > n0) begin
        exp_lat = (vecs[v].bits == 0) ? 84 : (vecs[v].bits >= 16) ? 36 : 21 + vecs[v].bits;
        chk("vec_grant_idx", 32'(last_grant_idx), 32'(vecs[v].id));
        chk("vec_grant_lat", 32'(last_grant_cyc - pc), 32'd1);
        chk("vec_grant_cnt", 32'(grant_cnt - g0), 32'd1);
        chk("vec_frame", 32'(last_frame), 32'({vecs[v].a, vecs[v].b, vecs[v].op}));
        chk("vec_frame_len", 32'(last_n), 32'(FW));
        chk("vec_rsp_id", 32'(rsp_log[n0].id), 32'(vecs[v].id));
        chk("vec_rsp_data", 32'(rsp_log[n0].data), 32'(vecs[v].exp_data));
        chk("vec_rsp_err", 32'(rsp_log[n0].err), 32'(vecs[v].exp_err));
        chk("vec_rsp_lat", 32'(rsp_log[n0].cyc - last_grant_cyc), 32'(exp_lat));
      end
    end

    // Backpressure: result held, pending requester 2 must not be granted
    alu_bits = 16;
    tick();
    tick();
    auto_ack = 1'b0;
    post(1, 8'h21, 8'h10, 3'b000);
    k = 0;
    while (!rsp_valid && k < 300) begin
      tick();
      k++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    post(2, 8'h07, 8'h06, 3'b101);
    g0 = grant_cnt;
    viol = 0;
    repeat (20) begin
      tick();
      if (enable_n !== 1'b1 || req_ready[2] !== 1'b0 || rsp_valid !== 1'b1) viol++;
    end
    chk("bp_stall_viol", 32'(viol), 32'd0);
    chk("bp_no_grant", 32'(grant_cnt - g0), 32'd0);
    chk("bp_rsp_id", 32'(rsp_id), 32'd1);
    chk("bp_rsp_data", 32'(rsp_data), 32'h0031);
    rsp_ready = 1'b1;
    ac = cyc;
    auto_ack = 1'b1;
    n0 = rsp_log.size();
    k = 0;
    while (grant_cnt == g0 && k < 10) begin
      tick();
      k++;
    end
    chk("bp_grant_idx", 32'(last_grant_idx), 32'd2);
    chk("bp_grant_lat", 32'(last_grant_cyc - ac), 32'd2);
    wait_rsps(n0 + 1, 200);
    if (rsp_log.size() > n0) chk("bp_rsp2_data", 32'(rsp_log[n0].data), 32'h002A);

    // Reset in the middle of SEND
    tick();
    tick();
    post(3, 8'h55, 8'h66, 3'b000);
    k = 0;
    while (enable_n && k < 10) begin
      tick();
      k++;
    end
    chk("rst_send_started", 32'(enable_n), 32'd0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort_enable_n", 32'(enable_n), 32'd1);
    chk("rst_abort_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    n0 = rsp_log.size();
    repeat (100) tick();
    chk("rst_no_rsp", 32'(rsp_log.size()), 32'(n0));
    g0 = grant_log.size();
    post(3, 8'h11, 8'h22, 3'b000);
    post(0, 8'h33, 8'h44, 3'b000);
    wait_rsps(n0 + 2, 200);
    if (rsp_log.size() >= n0 + 2) begin
      chk("rst_prio_first", 32'(rsp_log[n0].id), 32'd0);
      chk("rst_prio_second", 32'(rsp_log[n0 + 1].id), 32'd3);
      chk("rst_prio_data", 32'(rsp_log[n0].data), 32'h0077);
    end

    // Random batches against a round-robin reference over the pending set
    ref_ptr = 3;
    for (int bt = 0; bt < 20; bt++) begin
      tick();
      tick();
      mask = 4'($urandom_range(1, 15));
      alu_lat = $urandom_range(1, 4);
      for (int i = 0; i < NREQ; i++)
        if (mask[i]) post(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)));
      exp_ids = {};
      for (int s = 1; s <= NREQ; s++) begin
        if (mask[(ref_ptr + s) % NREQ]) exp_ids.push_back((ref_ptr + s) % NREQ);
      end
      cnt = exp_ids.size();
      ref_ptr = exp_ids[cnt - 1];
      n0 = rsp_log.size();
      wait_rsps(n0 + cnt, 100 * cnt);
      for (int j = 0; j < cnt; j++) begin
        if (rsp_log.size() > n0 + j) begin
          chk("rnd_rsp_id", 32'(rsp_log[n0 + j].id), 32'(exp_ids[j]));
          chk("rnd_rsp_data", 32'(rsp_log[n0 + j].data),
              32'(alu_ref(pa[exp_ids[j]], pb[exp_ids[j]], pop[exp_ids[j]])));
          chk("rnd_rsp_err", 32'(rsp_log[n0 + j].err), 32'd0);
        end
      end
    end

    tick();
    chk("ready_onehot", 32'(onehot_bad), 32'd0);
    chk("grant_count", 32'(grant_cnt), 32'(posted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Round-robin scheduler that shares one serial ALU (vdic_dut_2022) between NREQ parallel requesters.
- It serializes the granted command onto din/enable_n, waits for the ALU result, and deserializes dout while dout_valid is high.
- It returns the tagged result to the requesters.
- Sits between the requester fabric and the ALU; the ALU is used by exactly one command at a time.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DATA_W, 8, operand width A and B
- OP_W, 3, opcode width
- RES_W, 16, result width shifted out by the ALU
- TIMEOUT_CYC, 64, max cycles from end of frame to first dout_valid

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-hot accept pulse
- req_a  in  NREQ*DATA_W  operand A, slice i for requester i
- req_b  in  NREQ*DATA_W  operand B, slice i
- req_op  in  NREQ*OP_W  opcode, slice i
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  $clog2(NREQ)  requester index of result
- rsp_data  out  RES_W  result word
- rsp_err  out  1  timeout or truncated result
- enable_n  out  1  ALU frame enable, active low
- din  out  1  ALU serial data in
- dout  in  1  ALU serial data out
- dout_valid  in  1  ALU result bit valid

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, enable_n=1, din=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - RR pointer=NREQ-1, so requester 0 has first priority.
- IDLE: if any req_valid, go to GRANT. Otherwise stay.
- GRANT (1 cycle):
  - Pick the first valid requester searching from pointer+1 with wrap-around.
  - Pulse req_ready[g]=1 for this single cycle.
  - Latch {a,b,op} into the frame shift register of FRAME_W=2*DATA_W+OP_W bits; latch id=g; pointer=g.
  - Go to SEND.
- SEND (FRAME_W cycles):
  - enable_n=0; din = frame MSB, sent as A MSB-first, then B MSB-first, then op MSB-first.
  - Shift one bit per clock, with a bit counter.
  - After the last bit, go to WAIT.
- WAIT:
  - enable_n=1, din=0; the timeout counter counts up.
  - dout_valid=1: capture the bit, go to RECV.
  - Counter reaches TIMEOUT_CYC: rsp_err=1, rsp_data=0, go to RESP.
- RECV:
  - Shift dout into the result register MSB-first while dout_valid=1, until RES_W bits are captured, then go to RESP.
  - dout_valid dropping before RES_W bits: rsp_err=1, keep the partial value left-aligned, go to RESP.
  - Any further dout_valid after RES_W bits is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable.
  - rsp_valid && rsp_ready: rsp_valid=0, rsp_err=0, go to IDLE.
  - No new grant is made while in RESP (backpressure stalls the ALU).
- Latency, no contention: req_ready 1 cycle after req_valid seen in IDLE. Frame occupies FRAME_W cycles. rsp_valid on the cycle after the last result bit.
- Requester rules:
  - Must hold req_valid and payload stable until req_ready.
  - req_valid deasserted before grant is legal; the requester is simply skipped.
- Simultaneous events:
  - A request arriving in any non-IDLE state waits.
  - A dout_valid arriving in the same cycle as timeout expiry counts as valid data; the timeout does not fire.
- Reset mid-operation: immediate abort. enable_n returns to 1 asynchronously and the in-flight command is lost (no response).

Decomposition:
- alu_sched_pkg:
  - state enum (IDLE, GRANT, SEND, WAIT, RECV, RESP)
  - FRAME_W function of DATA_W/OP_W
  - default parameter constants
  - opcode enum shared with the ALU testbench
- Sub-module rr_arbiter: parameterized NREQ. Inputs: req vector, pointer, enable. Outputs: one-hot grant, grant index. Registered pointer update.

Test Plan:
- Single request from requester 0 (a=8'h12, b=8'h34, op=3'b000):
  - din shows 19 bits 0x12,0x34,000 MSB-first with enable_n=0 for exactly 19 cycles.
  - ALU model returns 16'h0046.
  - rsp_valid with rsp_id=0, rsp_data=16'h0046, rsp_err=0.
- All four requesters valid in the same cycle, each held until granted:
  - Grant order 0,1,2,3, then 0 again on re-request.
  - Exactly one req_ready pulse per command.
- ALU model never asserts dout_valid:
  - After TIMEOUT_CYC=64 idle cycles: rsp_valid=1, rsp_err=1, rsp_data=0.
  - Next request still served correctly.
- dout_valid held for only 10 bits:
  - rsp_err=1, rsp_data has the 10 captured bits in [15:6] and zeros below.
- rsp_ready held low 20 cycles with requester 2 pending:
  - enable_n stays 1 and req_ready[2]=0 throughout.
  - Grant to 2 occurs 1 cycle after rsp_ready handshake plus IDLE.
- rst_n pulsed low in the middle of SEND:
  - enable_n=1 immediately and no rsp_valid.
  - Priority pointer restored: requester 0 wins the next contention with requester 3.
